// File: rtl/instruction_register_mb.sv
// instruction_register_mb: multi-byte instruction register for the SAP datapath.
// Captures an opcode word followed by 0, 1 or 2 extension words (selected per
// opcode through EXT1_MASK / EXT2_MASK) and drives the assembled operand.
// Build option: define IR_TRISTATE_EN to float data_out when Ei_bar is high
// (shared W bus); otherwise data_out is driven to zero (muxed bus).
module instruction_register_mb #(
  parameter int                  WORD_W    = 8,
  parameter int                  OPC_W     = 4,
  parameter logic [2**OPC_W-1:0] EXT1_MASK = '0,
  parameter logic [2**OPC_W-1:0] EXT2_MASK = '0
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  Li_bar,
  input  logic                  Ei_bar,
  input  logic                  flush,
  input  logic [WORD_W-1:0]     data_in,
  output logic [OPC_W-1:0]      instr_out,
  output logic [2*WORD_W-1:0]   data_out,
  output logic                  ext_pending,
  output logic                  ir_valid
);

  localparam int ADDR_W = WORD_W - OPC_W;

  localparam logic [1:0] S_OPC  = 2'd0;
  localparam logic [1:0] S_EXT1 = 2'd1;
  localparam logic [1:0] S_EXT2 = 2'd2;

  // Number of extension words an opcode needs; the two-word mask wins.
  function automatic logic [1:0] ext_count(input logic [OPC_W-1:0] opc);
    if (EXT2_MASK[opc]) begin
      ext_count = 2'd2;
    end else if (EXT1_MASK[opc]) begin
      ext_count = 2'd1;
    end else begin
      ext_count = 2'd0;
    end
  endfunction

  logic [1:0]          state_q, state_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [ADDR_W-1:0]   low_q, low_d;
  logic [WORD_W-1:0]   ext1_q, ext1_d;
  logic [WORD_W-1:0]   ext2_q, ext2_d;
  logic                valid_q, valid_d;

  logic [OPC_W-1:0]    new_opc_s;
  logic [1:0]          n_new_s;
  logic [1:0]          n_cur_s;
  logic [2*WORD_W-1:0] operand_s;

  assign new_opc_s = data_in[WORD_W-1 -: OPC_W];
  assign n_new_s   = ext_count(new_opc_s);
  assign n_cur_s   = ext_count(opc_q);

  // Next-state logic: flush beats load; idle cycles hold everything.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    low_d   = low_q;
    ext1_d  = ext1_q;
    ext2_d  = ext2_q;
    valid_d = valid_q;
    if (flush) begin
      // Abandon the fetch but keep register contents (stale opcode visible).
      state_d = S_OPC;
      valid_d = 1'b0;
    end else if (!Li_bar) begin
      case (state_q)
        S_OPC: begin
          opc_d  = new_opc_s;
          low_d  = data_in[ADDR_W-1:0];
          ext1_d = '0;
          ext2_d = '0;
          if (n_new_s == 2'd0) begin
            state_d = S_OPC;
            valid_d = 1'b1;
          end else begin
            state_d = S_EXT1;
            valid_d = 1'b0;
          end
        end
        S_EXT1: begin
          ext1_d = data_in;
          if (n_cur_s == 2'd2) begin
            state_d = S_EXT2;
          end else begin
            state_d = S_OPC;
            valid_d = 1'b1;
          end
        end
        S_EXT2: begin
          ext2_d  = data_in;
          state_d = S_OPC;
          valid_d = 1'b1;
        end
        default: begin
          state_d = S_OPC;
          valid_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_OPC;
      opc_q   <= '0;
      low_q   <= '0;
      ext1_q  <= '0;
      ext2_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      low_q   <= low_d;
      ext1_q  <= ext1_d;
      ext2_q  <= ext2_d;
      valid_q <= valid_d;
    end
  end

  // Short instructions carry their operand in the opcode word's low field;
  // extended ones use the extension words, first word in the low byte.
  assign operand_s = (n_cur_s == 2'd0) ? {{(2*WORD_W-ADDR_W){1'b0}}, low_q}
                                       : {ext2_q, ext1_q};

  assign instr_out   = opc_q;
  assign ir_valid    = valid_q;
  assign ext_pending = (state_q != S_OPC);

`ifdef IR_TRISTATE_EN
  assign data_out = Ei_bar ? {(2*WORD_W){1'bz}} : operand_s;
`else
  assign data_out = Ei_bar ? {(2*WORD_W){1'b0}} : operand_s;
`endif

endmodule
